// File: rtl/floo_meta_slot_table.sv
// Per-transaction metadata table: allocates a unique downstream slot ID per request
// and restores the original ID plus metadata on the matching response.
module floo_meta_slot_table #(
    parameter  int InIdWidth  = 4,
    parameter  int OutIdWidth = 3,
    parameter  int NumSlots   = 8,
    parameter  int MetaWidth  = 8,
    parameter  int OrderMode  = 0,
    localparam int CntWidth   = $clog2(NumSlots + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [InIdWidth-1:0]  req_id_i,
    input  logic [MetaWidth-1:0]  req_meta_i,
    output logic                  req_valid_o,
    input  logic                  req_ready_i,
    output logic [OutIdWidth-1:0] req_id_o,
    input  logic                  rsp_valid_i,
    output logic                  rsp_ready_o,
    input  logic [OutIdWidth-1:0] rsp_id_i,
    input  logic                  rsp_last_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [InIdWidth-1:0]  rsp_id_o,
    output logic [MetaWidth-1:0]  rsp_meta_o,
    output logic [CntWidth-1:0]   count_o,
    output logic                  full_o,
    output logic                  err_o
);

    if (NumSlots < 1 || NumSlots > (1 << OutIdWidth)) begin : g_bad_params
        $error("floo_meta_slot_table: NumSlots must be in 1..2**OutIdWidth");
    end

    logic [NumSlots-1:0]   r_valid;
    logic [InIdWidth-1:0]  r_in_id [NumSlots];
    logic [MetaWidth-1:0]  r_meta  [NumSlots];
    logic [CntWidth-1:0]   r_count;
    logic                  r_err;
    logic                  r_stalled;
    logic [OutIdWidth-1:0] r_stall_idx;

    logic [NumSlots-1:0]   w_free_vec;
    logic [NumSlots-1:0]   w_id_match;
    logic [OutIdWidth-1:0] w_lowest_free;
    logic [OutIdWidth-1:0] w_alloc_idx;
    logic                  w_can_alloc;
    logic                  w_alloc_fire;
    logic                  w_rsp_hs;
    logic                  w_rsp_hit;
    logic                  w_free_fire;
    logic [InIdWidth-1:0]  w_rsp_id;
    logic [MetaWidth-1:0]  w_rsp_meta;

    assign w_free_vec = ~r_valid;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_lowest_free = '0;
        for (int i = NumSlots - 1; i >= 0; i--) begin
            if (w_free_vec[i]) w_lowest_free = OutIdWidth'(i);
        end
    end

    always_comb begin
        w_id_match = '0;
        for (int i = 0; i < NumSlots; i++) begin
            w_id_match[i] = r_valid[i] && (r_in_id[i] == req_id_i);
        end
    end

    // A held request keeps the index it was first offered with until it fires.
    assign w_alloc_idx  = r_stalled ? r_stall_idx : w_lowest_free;
    assign w_can_alloc  = (|w_free_vec) && ((OrderMode == 0) || !(|w_id_match));
    assign req_valid_o  = req_valid_i && w_can_alloc;
    assign req_ready_o  = req_ready_i && w_can_alloc;
    assign req_id_o     = w_alloc_idx;
    assign w_alloc_fire = req_valid_o && req_ready_i;

    always_comb begin
        w_rsp_hit  = 1'b0;
        w_rsp_id   = '0;
        w_rsp_meta = '0;
        for (int i = 0; i < NumSlots; i++) begin
            if (rsp_id_i == OutIdWidth'(i) && r_valid[i]) begin
                w_rsp_hit  = 1'b1;
                w_rsp_id   = r_in_id[i];
                w_rsp_meta = r_meta[i];
            end
        end
    end

    assign w_rsp_hs    = rsp_valid_i && rsp_ready_i;
    assign w_free_fire = w_rsp_hs && rsp_last_i && w_rsp_hit;
    assign rsp_valid_o = rsp_valid_i;
    assign rsp_ready_o = rsp_ready_i;
    assign rsp_id_o    = w_rsp_id;
    assign rsp_meta_o  = w_rsp_meta;

    // NOTE: the slot storage is reset too, so responses after reset read back zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= '0;
            for (int i = 0; i < NumSlots; i++) begin
                r_in_id[i] <= '0;
                r_meta[i]  <= '0;
            end
        end else begin
            // Allocation and free never target the same slot: one needs it free, the other valid.
            for (int i = 0; i < NumSlots; i++) begin
                if (w_alloc_fire && w_alloc_idx == OutIdWidth'(i)) begin
                    r_valid[i] <= 1'b1;
                    r_in_id[i] <= req_id_i;
                    r_meta[i]  <= req_meta_i;
                end
                if (w_free_fire && rsp_id_i == OutIdWidth'(i)) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count     <= '0;
            r_err       <= 1'b0;
            r_stalled   <= 1'b0;
            r_stall_idx <= '0;
        end else begin
            if (w_alloc_fire && !w_free_fire) begin
                r_count <= r_count + CntWidth'(1);
            end else if (!w_alloc_fire && w_free_fire) begin
                r_count <= r_count - CntWidth'(1);
            end
            r_err     <= w_rsp_hs && !w_rsp_hit;
            r_stalled <= req_valid_o && !req_ready_i;
            if (req_valid_o && !req_ready_i) begin
                r_stall_idx <= w_alloc_idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (r_count <= CntWidth'(NumSlots))
            else $error("floo_meta_slot_table: occupancy above NumSlots");
        end
    end

    assign count_o = r_count;
    assign full_o  = (r_count == CntWidth'(NumSlots));
    assign err_o   = r_err;

endmodule

// File: tb/tb_floo_meta_slot_table.sv
// Directed bench for floo_meta_slot_table: unordered instance plus a same-ID serialised instance.
module tb_floo_meta_slot_table;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;

    logic       req_valid_i, req_ready_o, req_valid_o, req_ready_i;
    logic [3:0] req_id_i;
    logic [7:0] req_meta_i;
    logic [2:0] req_id_o;
    logic       rsp_valid_i, rsp_ready_o, rsp_last_i, rsp_valid_o, rsp_ready_i;
    logic [2:0] rsp_id_i;
    logic [3:0] rsp_id_o;
    logic [7:0] rsp_meta_o;
    logic [3:0] count_o;
    logic       full_o, err_o;

    logic       m_req_valid_i, m_req_ready_o, m_req_valid_o, m_req_ready_i;
    logic [3:0] m_req_id_i;
    logic [7:0] m_req_meta_i;
    logic [2:0] m_req_id_o;
    logic       m_rsp_valid_i, m_rsp_ready_o, m_rsp_last_i, m_rsp_valid_o, m_rsp_ready_i;
    logic [2:0] m_rsp_id_i;
    logic [3:0] m_rsp_id_o;
    logic [7:0] m_rsp_meta_o;
    logic [3:0] m_count_o;
    logic       m_full_o, m_err_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    floo_meta_slot_table #(.OrderMode(0)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_id_i(req_id_i),
        .req_meta_i(req_meta_i), .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
        .req_id_o(req_id_o), .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o),
        .rsp_id_i(rsp_id_i), .rsp_last_i(rsp_last_i), .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o), .rsp_meta_o(rsp_meta_o),
        .count_o(count_o), .full_o(full_o), .err_o(err_o)
    );

    floo_meta_slot_table #(.OrderMode(1)) dut_ord (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(m_req_valid_i), .req_ready_o(m_req_ready_o), .req_id_i(m_req_id_i),
        .req_meta_i(m_req_meta_i), .req_valid_o(m_req_valid_o), .req_ready_i(m_req_ready_i),
        .req_id_o(m_req_id_o), .rsp_valid_i(m_rsp_valid_i), .rsp_ready_o(m_rsp_ready_o),
        .rsp_id_i(m_rsp_id_i), .rsp_last_i(m_rsp_last_i), .rsp_valid_o(m_rsp_valid_o),
        .rsp_ready_i(m_rsp_ready_i), .rsp_id_o(m_rsp_id_o), .rsp_meta_o(m_rsp_meta_o),
        .count_o(m_count_o), .full_o(m_full_o), .err_o(m_err_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled in between edges.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [6:0] burst_ready;
        logic [6:0] burst_last;
        burst_ready = 7'b1010101;
        burst_last  = 7'b1100000;

        req_valid_i = 0; req_ready_i = 0; req_id_i = 0; req_meta_i = 0;
        rsp_valid_i = 0; rsp_ready_i = 0; rsp_id_i = 0; rsp_last_i = 0;
        m_req_valid_i = 0; m_req_ready_i = 0; m_req_id_i = 0; m_req_meta_i = 0;
        m_rsp_valid_i = 0; m_rsp_ready_i = 0; m_rsp_id_i = 0; m_rsp_last_i = 0;

        // Reset state
        #2 rst_i = 1'b1;
        #1;
        check("reset_count", count_o, 0);
        check("reset_full", full_o, 0);
        check("reset_err", err_o, 0);
        check("reset_req_valid_o", req_valid_o, 0);
        tick();
        rst_i = 1'b0;

        // Fill: ids 0..7, meta A0..A7
        req_ready_i = 1'b1;
        req_valid_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            req_id_i   = 4'(k);
            req_meta_i = 8'hA0 + 8'(k);
            #1;
            check("fill_req_valid_o", req_valid_o, 1);
            check("fill_req_id_o", req_id_o, k);
            tick();
        end
        req_id_i = 4'h9; req_meta_i = 8'hA8;
        #1;
        check("full_count", count_o, 8);
        check("full_flag", full_o, 1);
        check("full_req_valid_o", req_valid_o, 0);
        check("full_req_ready_o", req_ready_o, 0);
        req_valid_i = 1'b0;

        // Out-of-order single-beat returns 5, 2, 7
        rsp_valid_i = 1; rsp_ready_i = 1; rsp_last_i = 1;
        rsp_id_i = 3'd5; #1;
        check("ooo5_id", rsp_id_o, 5);
        check("ooo5_meta", rsp_meta_o, 8'hA5);
        check("ooo5_valid", rsp_valid_o, 1);
        tick();
        rsp_id_i = 3'd2; #1;
        check("ooo2_id", rsp_id_o, 2);
        check("ooo2_meta", rsp_meta_o, 8'hA2);
        tick();
        rsp_id_i = 3'd7; #1;
        check("ooo7_id", rsp_id_o, 7);
        check("ooo7_meta", rsp_meta_o, 8'hA7);
        tick();
        rsp_valid_i = 0;
        check("ooo_count", count_o, 5);
        check("ooo_full", full_o, 0);
        req_valid_i = 1; req_id_i = 4'hB; req_meta_i = 8'hB0; #1;
        check("realloc_id", req_id_o, 2);
        tick();
        req_valid_i = 0;
        check("realloc_count", count_o, 6);

        // Four-beat burst to slot 3 with ready toggling
        for (int k = 0; k < 7; k++) begin
            rsp_valid_i = 1; rsp_id_i = 3'd3;
            rsp_ready_i = burst_ready[k];
            rsp_last_i  = burst_last[k];
            #1;
            check("burst_id", rsp_id_o, 3);
            check("burst_meta", rsp_meta_o, 8'hA3);
            check("burst_ready_o", rsp_ready_o, burst_ready[k]);
            tick();
            check("burst_count", count_o, (k < 6) ? 6 : 5);
        end
        rsp_valid_i = 0; rsp_ready_i = 1; rsp_last_i = 1;

        // Error: response to freed slot 5
        rsp_valid_i = 1; rsp_id_i = 3'd5; #1;
        check("err_rsp_id", rsp_id_o, 0);
        check("err_rsp_meta", rsp_meta_o, 0);
        check("err_rsp_valid", rsp_valid_o, 1);
        tick();
        rsp_valid_i = 0;
        check("err_pulse", err_o, 1);
        check("err_count", count_o, 5);
        tick();
        check("err_clear", err_o, 0);

        // Refill free slots 3, 5, 7
        req_valid_i = 1;
        req_id_i = 4'hC; req_meta_i = 8'hC0; #1;
        check("refill_c", req_id_o, 3);
        tick();
        req_id_i = 4'hD; req_meta_i = 8'hD0; #1;
        check("refill_d", req_id_o, 5);
        tick();
        req_id_i = 4'hE; req_meta_i = 8'hE0; #1;
        check("refill_e", req_id_o, 7);
        tick();
        check("refill_full", full_o, 1);

        // Full: free slot 0 while a request waits; it allocates slot 0 one cycle later
        req_id_i = 4'hF; req_meta_i = 8'hF0;
        rsp_valid_i = 1; rsp_id_i = 3'd0; #1;
        check("simul_req_valid_o", req_valid_o, 0);
        check("simul_req_ready_o", req_ready_o, 0);
        check("simul_rsp_meta", rsp_meta_o, 8'hA0);
        tick();
        rsp_valid_i = 0;
        check("simul_count_mid", count_o, 7);
        #1;
        check("simul_next_valid", req_valid_o, 1);
        check("simul_next_id", req_id_o, 0);
        tick();
        req_valid_i = 0;
        check("simul_count", count_o, 8);
        check("simul_full", full_o, 1);

        // Free slot 1, then free slot 2 while allocating slot 1: count unchanged
        rsp_valid_i = 1; rsp_id_i = 3'd1; #1;
        check("free1_meta", rsp_meta_o, 8'hA1);
        tick();
        check("free1_count", count_o, 7);
        rsp_id_i = 3'd2;
        req_valid_i = 1; req_id_i = 4'h9; req_meta_i = 8'h90; #1;
        check("swap_req_id", req_id_o, 1);
        check("swap_rsp_id", rsp_id_o, 4'hB);
        check("swap_rsp_meta", rsp_meta_o, 8'hB0);
        tick();
        rsp_valid_i = 0;
        check("swap_count", count_o, 7);

        // Stalled request keeps slot 2 even when lower slot 0 frees meanwhile
        req_id_i = 4'h5; req_meta_i = 8'h55; req_ready_i = 0; #1;
        check("stall_valid_o", req_valid_o, 1);
        check("stall_ready_o", req_ready_o, 0);
        check("stall_id0", req_id_o, 2);
        tick();
        rsp_valid_i = 1; rsp_id_i = 3'd0; #1;
        check("stall_id1", req_id_o, 2);
        check("stall_rsp_meta", rsp_meta_o, 8'hF0);
        tick();
        rsp_valid_i = 0;
        check("stall_count_free", count_o, 6);
        req_ready_i = 1; #1;
        check("stall_id2", req_id_o, 2);
        check("stall_ready_o2", req_ready_o, 1);
        tick();
        req_valid_i = 0;
        check("stall_count_fire", count_o, 7);

        // Reset mid-flight discards everything
        rst_i = 1; #1;
        check("rst_async_count", count_o, 0);
        check("rst_async_full", full_o, 0);
        tick();
        check("rst_count", count_o, 0);
        rst_i = 0;
        rsp_valid_i = 1; rsp_ready_i = 1; rsp_last_i = 1; rsp_id_i = 3'd4; #1;
        check("post_rst_rsp_id", rsp_id_o, 0);
        check("post_rst_rsp_meta", rsp_meta_o, 0);
        tick();
        rsp_valid_i = 0;
        check("post_rst_err", err_o, 1);
        check("post_rst_count", count_o, 0);
        tick();
        check("post_rst_err_clear", err_o, 0);

        // Same-ID serialised instance
        m_req_ready_i = 1; m_rsp_ready_i = 1; m_rsp_last_i = 1;
        m_req_valid_i = 1; m_req_id_i = 4'd6; m_req_meta_i = 8'h16; #1;
        check("ord_first_id", m_req_id_o, 0);
        tick();
        m_req_meta_i = 8'h26; #1;
        check("ord_dup_valid_o", m_req_valid_o, 0);
        check("ord_dup_ready_o", m_req_ready_o, 0);
        tick();
        m_req_id_i = 4'd4; m_req_meta_i = 8'h14; #1;
        check("ord_other_valid_o", m_req_valid_o, 1);
        check("ord_other_id", m_req_id_o, 1);
        tick();
        m_req_id_i = 4'd6; m_req_meta_i = 8'h26;
        m_rsp_valid_i = 1; m_rsp_id_i = 3'd0; #1;
        check("ord_same_cycle_valid_o", m_req_valid_o, 0);
        check("ord_free_rsp_id", m_rsp_id_o, 6);
        check("ord_free_rsp_meta", m_rsp_meta_o, 8'h16);
        tick();
        m_rsp_valid_i = 0; #1;
        check("ord_next_valid_o", m_req_valid_o, 1);
        check("ord_next_id", m_req_id_o, 0);
        tick();
        m_req_valid_i = 0;
        check("ord_count", m_count_o, 2);
        m_rsp_valid_i = 1; m_rsp_id_i = 3'd0; #1;
        check("ord_new_rsp_id", m_rsp_id_o, 6);
        check("ord_new_rsp_meta", m_rsp_meta_o, 8'h26);
        tick();
        m_rsp_valid_i = 0;
        check("ord_final_count", m_count_o, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
